cp0_exc_ctrl: RTL

- Coprocessor-0 register file and exception/interrupt arbiter.
- Sits directly downstream of the M-stage exception detector and consumes its 5-bit ExcCode, together with the M-stage PC, BD flag, external HWInt lines and mtc0/eret controls.
- Decides each cycle whether to take an interrupt or exception, records SR/Cause/EPC state, and drives the request that flushes the pipeline and redirects fetch to the handler.

---
 rtl/cp0_exc_ctrl_pkg.sv | 8 +
 rtl/cp0_exc_ctrl.sv | 91 +++++++++
 2 files changed

// File: rtl/cp0_exc_ctrl_pkg.sv
// cp0_exc_ctrl_pkg: shared ExcCode values, CP0 register numbers, field positions and defaults.
package cp0_exc_ctrl_pkg;
  localparam logic [4:0] EXC_INT = 5'd0, EXC_ADEL = 5'd4, EXC_ADES = 5'd5, EXC_RI = 5'd10, EXC_OV = 5'd12;
  localparam logic [4:0] REG_BADVADDR = 5'd8, REG_SR = 5'd12, REG_CAUSE = 5'd13, REG_EPC = 5'd14, REG_PRID = 5'd15;
  localparam int SR_IE = 0, SR_EXL = 1, IM_LO = 10, IM_HI = 15;
  localparam int CAUSE_BD = 31, IP_LO = 10, IP_HI = 15, EXC_LO = 2, EXC_HI = 6;
  localparam logic [31:0] HANDLER_PC_DEF = 32'h0000_4180, PRID_DEF = 32'h0000_4D50;
endpackage

// File: rtl/cp0_exc_ctrl.sv
// cp0_exc_ctrl: CP0 SR/Cause/EPC/PRId register file and interrupt/exception arbiter.
// Optional BadVAddr register and VAddr_M port enabled by defining CP0_BADVADDR_EN.
module cp0_exc_ctrl
  import cp0_exc_ctrl_pkg::*;
#(
  parameter logic [31:0] PRID_VAL   = PRID_DEF,
  parameter logic [31:0] HANDLER_PC = HANDLER_PC_DEF
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [4:0]  A1,
  input  logic [4:0]  A2,
  input  logic [31:0] DIn,
  input  logic        We,
  input  logic [31:0] PC_M,
  input  logic        BD_M,
  input  logic [6:2]  ExcCode_M,
  input  logic [7:2]  HWInt,
  input  logic        EXLClr,
`ifdef CP0_BADVADDR_EN
  input  logic [31:0] VAddr_M,
`endif
  output logic [31:0] DOut,
  output logic [31:0] EPC_out,
  output logic        Req,
  output logic [31:0] Handler_Addr
);
  logic [5:0]  sr_im, cause_ip;
  logic        sr_exl, sr_ie, cause_bd;
  logic [4:0]  cause_exc;
  logic [31:0] epc, sr_w, cause_w, bva_w, pc_al;
  logic        int_req, exc_req;
  assign int_req = reset & (|(HWInt & sr_im)) & sr_ie & ~sr_exl;
  assign exc_req = reset & (ExcCode_M != EXC_INT) & ~sr_exl;
  assign Req = int_req | exc_req;
  assign pc_al = PC_M & ~32'h3;
  assign EPC_out = epc;
  assign Handler_Addr = HANDLER_PC;
  always_comb begin
    sr_w = '0;
    sr_w[IM_HI:IM_LO] = sr_im;
    sr_w[SR_EXL] = sr_exl;
    sr_w[SR_IE] = sr_ie;
    cause_w = '0;
    cause_w[CAUSE_BD] = cause_bd;
    cause_w[IP_HI:IP_LO] = cause_ip;
    cause_w[EXC_HI:EXC_LO] = cause_exc;
  end
`ifdef CP0_BADVADDR_EN
  logic [31:0] bad_vaddr;
  assign bva_w = bad_vaddr;
  always_ff @(posedge clk)
    if (!reset) bad_vaddr <= '0;
    else if (exc_req && !int_req && (ExcCode_M == EXC_ADEL || ExcCode_M == EXC_ADES)) bad_vaddr <= VAddr_M;
`else
  assign bva_w = '0;
`endif
  assign DOut = A1 == REG_SR       ? sr_w :
                A1 == REG_CAUSE    ? cause_w :
                A1 == REG_EPC      ? epc :
                A1 == REG_PRID     ? PRID_VAL :
                A1 == REG_BADVADDR ? bva_w : '0;
  // A taken request squashes any concurrent mtc0 or eret from the same instruction.
  always_ff @(posedge clk) begin
    if (!reset) begin
      sr_im <= '0;
      sr_exl <= 1'b0;
      sr_ie <= 1'b0;
      cause_bd <= 1'b0;
      cause_ip <= '0;
      cause_exc <= '0;
      epc <= '0;
    end else begin
      cause_ip <= HWInt;
      if (Req) begin
        sr_exl <= 1'b1;
        cause_exc <= int_req ? EXC_INT : ExcCode_M;
        cause_bd <= BD_M;
        epc <= BD_M ? pc_al - 32'd4 : pc_al;
      end else begin
        if (We && A2 == REG_SR) begin
          sr_im <= DIn[IM_HI:IM_LO];
          sr_exl <= DIn[SR_EXL];
          sr_ie <= DIn[SR_IE];
        end
        if (We && A2 == REG_EPC) epc <= DIn & ~32'h3;
        if (EXLClr) sr_exl <= 1'b0;
      end
    end
  end
endmodule
